if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_i  input  1  downstream (decode) cannot accept; hold IF/ID register and PC.
REQ-005 redirect_i  input  1  branch/jump/trap redirect request.
REQ-006 redirect_pc_i  input  `PC_WIDTH  redirect target address.
REQ-007 pc_o  output  `PC_WIDTH  current fetch address, driven straight from the PC register to the fetch memory.
REQ-008 if_bus_instr_i  input  `INSTR_WIDTH  combinational instruction returned for pc_o.
REQ-009 if_bus_pc_misalign_i  input  1  fetch address not 4-byte aligned.
REQ-010 if_bus_bus_err_i  input  1  fetch bus error.
REQ-011 id_valid_o  output  1  IF/ID register holds a valid instruction.
REQ-012 id_pc_o  output  `PC_WIDTH  PC of the registered instruction.
REQ-013 id_instr_o  output  `INSTR_WIDTH  registered instruction word.
REQ-014 id_exc_misalign_o  output  1  registered misalign flag.
REQ-015 id_exc_bus_err_o  output  1  registered bus-error flag.

Function
REQ-016 Block SHALL hold one PC register, one IF/ID register (valid, pc, instr, two flags) and a 2-state FSM: RUN, HALT.
REQ-017 Fetch latency SHALL be one cycle: instruction at pc_o in cycle N appears on id_* in cycle N+1.
REQ-018 RUN, !stall_i, !redirect_i: IF/ID SHALL capture {1, pc_o, if_bus_instr_i, flags}; PC <= PC + 4.
REQ-019 PC + 4 SHALL wrap modulo 2^`PC_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-020 stall_i=1 without redirect_i: PC, IF/ID and FSM state SHALL hold unchanged.
REQ-021 redirect_i=1: SHALL take priority over stall_i and HALT; PC <= redirect_pc_i, id_valid_o <= 0, state <= RUN.
REQ-022 Captured fetch with either flag set (RUN, not stalled): state <= HALT; PC holds.
REQ-023 HALT: no new capture; PC holds; when !stall_i, id_valid_o <= 0, so the faulting entry is presented until accepted; exits only via redirect_i or rst.
REQ-024 redirect_pc_i SHALL be loaded unmodified; low bits are not masked, misalignment is reported via if_bus_pc_misalign_i.
REQ-025 Every output SHALL come from a register; no combinational input-to-output path.

Reset
REQ-026 rst=1 at a clock edge: PC <= RESET_PC, state <= RUN, id_valid_o <= 0, id_pc_o <= 0, id_instr_o <= 0, both id_exc_* <= 0.
REQ-027 rst SHALL override redirect_i and stall_i in the same cycle; first capture occurs on the first edge with rst=0.
REQ-028 rst asserted mid-stall or in HALT SHALL discard pending state with no residual valid.

Configuration
REQ-029 Macro IF_STAGE_EXC_EN: when defined, the flags are captured and HALT is used per REQ-022/023.
REQ-030 When IF_STAGE_EXC_EN is undefined, if_bus_pc_misalign_i and if_bus_bus_err_i SHALL be ignored, id_exc_* tied 0, and the FSM SHALL never leave RUN.

Verification
REQ-031 Reset release, memory word at 0x0 = 0x00000013, no stall -> cycle 1: id_valid_o=1, id_pc_o=0x0, id_instr_o=0x00000013; pc_o=0x4.
REQ-032 Sequential run, stall_i=1 for 3 cycles at pc_o=0x8 -> id_pc_o stays 0x4, pc_o stays 0x8; one cycle after stall drops, id_pc_o=0x8.
REQ-033 redirect_i=1, redirect_pc_i=0x100 with stall_i=1 simultaneously -> next cycle pc_o=0x100, id_valid_o=0; following cycle id_pc_o=0x100, id_valid_o=1.
REQ-034 With IF_STAGE_EXC_EN, redirect to 0x102 -> id_exc_misalign_o=1, id_pc_o=0x102, pc_o holds 0x102, id_valid_o drops to 0 next unstalled cycle; redirect to 0x200 resumes fetch.
REQ-035 Reset PC 32'hFFFF_FFFC -> first id_pc_o=0xFFFFFFFC, pc_o wraps to 0x0, no error.
REQ-036 Without IF_STAGE_EXC_EN, redirect to 0x102 -> id_exc_* stay 0, fetch continues at 0x106.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, one-cycle IF/ID register and a RUN/HALT FSM.
// Define IF_STAGE_EXC_EN to capture misalign/bus-error flags and halt on a faulting fetch.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module if_stage #(
  parameter logic [`PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    redirect_i,
  input  logic [`PC_WIDTH-1:0]    redirect_pc_i,
  output logic [`PC_WIDTH-1:0]    pc_o,
  input  logic [`INSTR_WIDTH-1:0] if_bus_instr_i,
  input  logic                    if_bus_pc_misalign_i,
  input  logic                    if_bus_bus_err_i,
  output logic                    id_valid_o,
  output logic [`PC_WIDTH-1:0]    id_pc_o,
  output logic [`INSTR_WIDTH-1:0] id_instr_o,
  output logic                    id_exc_misalign_o,
  output logic                    id_exc_bus_err_o,
  output logic                    dbg_state
);

  // Handshake: a capture happens on any edge with !rst, !redirect_i, !stall_i in RUN;
  // stall_i freezes everything, redirect_i overrides stall_i and HALT.
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                  state_q;
  logic [`PC_WIDTH-1:0]    pc_q;
  logic                    valid_q;
  logic [`PC_WIDTH-1:0]    id_pc_q;
  logic [`INSTR_WIDTH-1:0] id_instr_q;
  logic                    exc_mis_q;
  logic                    exc_berr_q;

  logic fetch_mis;
  logic fetch_berr;
  logic fetch_fault;

`ifdef IF_STAGE_EXC_EN
  assign fetch_mis  = if_bus_pc_misalign_i;
  assign fetch_berr = if_bus_bus_err_i;
`else
  logic unused_flags;
  assign unused_flags = if_bus_pc_misalign_i ^ if_bus_bus_err_i;
  assign fetch_mis    = 1'b0;
  assign fetch_berr   = 1'b0;
`endif
  assign fetch_fault = fetch_mis | fetch_berr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      exc_mis_q  <= 1'b0;
      exc_berr_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q    <= redirect_pc_i;
      valid_q <= 1'b0;
      state_q <= RUN;
    end else if (!stall_i) begin
      if (state_q == RUN) begin
        valid_q    <= 1'b1;
        id_pc_q    <= pc_q;
        id_instr_q <= if_bus_instr_i;
        exc_mis_q  <= fetch_mis;
        exc_berr_q <= fetch_berr;
        // A faulting fetch parks the PC so nothing past it is fetched.
        if (fetch_fault) state_q <= HALT;
        else             pc_q    <= pc_q + `PC_WIDTH'(4);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pc_o              = pc_q;
  assign id_valid_o        = valid_q;
  assign id_pc_o           = id_pc_q;
  assign id_instr_o        = id_instr_q;
  assign id_exc_misalign_o = exc_mis_q;
  assign id_exc_bus_err_o  = exc_berr_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for the main pipeline behaviour
// plus a separate instance reset at the top of the address space.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_if_stage;

`ifdef IF_STAGE_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        bus_err = 1'b0;

  logic [31:0] pc, id_pc, id_instr, instr;
  logic        id_valid, id_mis, id_berr, st;

  // Fetch memory model: word 0 is a NOP, everything else is address-derived.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign instr = mem(pc);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .pc_o(pc), .if_bus_instr_i(instr),
    .if_bus_pc_misalign_i(pc[1:0] != 2'b00), .if_bus_bus_err_i(bus_err),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_instr_o(id_instr),
    .id_exc_misalign_o(id_mis), .id_exc_bus_err_o(id_berr), .dbg_state(st)
  );

  logic        rst2 = 1'b1;
  logic        zero_stall = 1'b0, zero_redirect = 1'b0, zero_berr = 1'b0;
  logic [31:0] zero_rpc = 32'h0;
  logic [31:0] pc2, id_pc2, id_instr2, instr2;
  logic        id_valid2, id_mis2, id_berr2, st2;

  assign instr2 = mem(pc2);

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .stall_i(zero_stall), .redirect_i(zero_redirect),
    .redirect_pc_i(zero_rpc), .pc_o(pc2), .if_bus_instr_i(instr2),
    .if_bus_pc_misalign_i(pc2[1:0] != 2'b00), .if_bus_bus_err_i(zero_berr),
    .id_valid_o(id_valid2), .id_pc_o(id_pc2), .id_instr_o(id_instr2),
    .id_exc_misalign_o(id_mis2), .id_exc_bus_err_o(id_berr2), .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, stall, redirect, berr;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        chk_id;
    logic [31:0] exp_id_pc, exp_instr;
    logic        exp_mis, exp_berr, exp_halt;
  } vec_t;

  vec_t vecs[$];

  // Expected IF/ID content for a valid capture of address a.
  task automatic add(input logic r, s, rd, be, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic chk,
                     input logic [31:0] eid, input logic [31:0] einstr,
                     input logic emis, ebe, ehalt);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.berr = be; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.chk_id = chk; v.exp_id_pc = eid;
    v.exp_instr = einstr; v.exp_mis = emis; v.exp_berr = ebe; v.exp_halt = ehalt;
    vecs.push_back(v);
  endtask

  task automatic drive_vec(input vec_t v);
    rst = v.rst; stall = v.stall; redirect = v.redirect;
    bus_err = v.berr; redirect_pc = v.rpc;
  endtask

  initial begin
    //   rst st rd be rpc         valid pc_o          chk id_pc        instr                 mis  berr halt
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,         1, 32'h0,        32'h0,                0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'h4,         1, 32'h0,        32'h0000_0013,        0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'h8,         1, 32'h4,        mem(32'h4),           0,   0,   0);
    add(0, 1, 0, 0, 32'h0,      1, 32'h8,         1, 32'h4,        mem(32'h4),           0,   0,   0);
    add(0, 1, 0, 0, 32'h0,      1, 32'h8,         1, 32'h4,        mem(32'h4),           0,   0,   0);
    add(0, 1, 0, 0, 32'h0,      1, 32'h8,         1, 32'h4,        mem(32'h4),           0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'hC,         1, 32'h8,        mem(32'h8),           0,   0,   0);
    add(0, 1, 1, 0, 32'h100,    0, 32'h100,       0, 32'h0,        32'h0,                0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'h104,       1, 32'h100,      mem(32'h100),         0,   0,   0);
    add(0, 0, 1, 0, 32'h102,    0, 32'h102,       0, 32'h0,        32'h0,                0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, EXC ? 32'h102 : 32'h106, 1, 32'h102, mem(32'h102), EXC, 0, EXC);
    add(0, 1, 0, 0, 32'h0,      1, EXC ? 32'h102 : 32'h106, 1, 32'h102, mem(32'h102), EXC, 0, EXC);
    add(0, 0, 0, 0, 32'h0,      !EXC, EXC ? 32'h102 : 32'h10A, !EXC, 32'h106, mem(32'h106), 0, 0, EXC);
    add(0, 0, 0, 0, 32'h0,      !EXC, EXC ? 32'h102 : 32'h10E, !EXC, 32'h10A, mem(32'h10A), 0, 0, EXC);
    add(0, 0, 1, 0, 32'h200,    0, 32'h200,       0, 32'h0,        32'h0,                0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'h204,       1, 32'h200,      mem(32'h200),         0,   0,   0);
    add(0, 0, 0, 1, 32'h0,      1, EXC ? 32'h204 : 32'h208, 1, 32'h204, mem(32'h204), 0, EXC, EXC);
    // Reset beats redirect and stall, and clears HALT when the flag build halted above.
    add(1, 1, 1, 0, 32'h300,    0, 32'h0,         1, 32'h0,        32'h0,                0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'h4,         1, 32'h0,        32'h0000_0013,        0,   0,   0);
    add(0, 1, 0, 0, 32'h0,      1, 32'h4,         1, 32'h0,        32'h0000_0013,        0,   0,   0);
    // Reset mid-stall: no residual valid.
    add(1, 1, 0, 0, 32'h0,      0, 32'h0,         1, 32'h0,        32'h0,                0,   0,   0);
    add(0, 0, 0, 0, 32'h0,      1, 32'h4,         1, 32'h0,        32'h0000_0013,        0,   0,   0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d pc_o", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d halt", i), {31'b0, st}, {31'b0, vecs[i].exp_halt});
      if (vecs[i].chk_id) begin
        check($sformatf("v%0d id_pc", i), id_pc, vecs[i].exp_id_pc);
        check($sformatf("v%0d id_instr", i), id_instr, vecs[i].exp_instr);
        check($sformatf("v%0d id_mis", i), {31'b0, id_mis}, {31'b0, vecs[i].exp_mis});
        check($sformatf("v%0d id_berr", i), {31'b0, id_berr}, {31'b0, vecs[i].exp_berr});
      end
    end

    // Wrap-around instance: reset PC at the top of the address space.
    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    check("wrap id_valid", {31'b0, id_valid2}, 32'h1);
    check("wrap id_pc", id_pc2, 32'hFFFF_FFFC);
    check("wrap id_instr", id_instr2, mem(32'hFFFF_FFFC));
    check("wrap pc_o", pc2, 32'h0);
    check("wrap flags", {30'b0, id_mis2, id_berr2}, 32'h0);
    check("wrap halt", {31'b0, st2}, 32'h0);
    @(posedge clk);
    #1;
    check("wrap next id_pc", id_pc2, 32'h0);
    check("wrap next id_instr", id_instr2, 32'h0000_0013);
    check("wrap next pc_o", pc2, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

endmodule
